cr_tlvp_ob_axis: RTL and testbench

//  Downstream egress stage of the TLV parser. Pops beats from the parser's FIFO-style

---
 rtl/cr_tlvp_ob_axis_pkg.sv | 26 ++
 rtl/cr_tlvp_ob_buf.sv | 76 +++++++
 rtl/cr_tlvp_ob_axis.sv | 121 ++++++++++++
 tb/tb_cr_tlvp_ob_axis.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_tlvp_ob_axis_pkg.sv
// -----------------------------------------------------------------------------
// cr_tlvp_ob_axis_pkg
// Shared types for the TLV parser egress stage (cr_tlvp_ob_axis).
//   axi4s_dp_bus_t       : AXI4-stream data-path beat (data, keep, user, last)
//   tlvp_ob_axis_state_e : frame tracking state (IDLE / ACTIVE)
// -----------------------------------------------------------------------------
package cr_tlvp_ob_axis_pkg;

   typedef struct packed {
      logic [63:0] tdata;
      logic [7:0]  tkeep;
      logic [7:0]  tuser;
      logic        tlast;
   } axi4s_dp_bus_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } tlvp_ob_axis_state_e;

   // Bits needed to hold an occupancy count of 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/cr_tlvp_ob_buf.sv
// -----------------------------------------------------------------------------
// cr_tlvp_ob_buf
// DEPTH-entry register FIFO of axi4s_dp_bus_t used as the local egress buffer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail
//   pop        : remove the head entry (ignored when empty)
//   dout       : current head entry (reads '0 straight out of reset)
//   occ        : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module cr_tlvp_ob_buf
   import cr_tlvp_ob_axis_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int OCC_W = occ_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  axi4s_dp_bus_t    din,
   input  logic             pop,
   output axi4s_dp_bus_t    dout,
   output logic [OCC_W-1:0] occ
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   axi4s_dp_bus_t    mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [OCC_W-1:0] occ_reg;
   logic             pop_eff;

   assign pop_eff = pop && (occ_reg != '0);
   assign dout    = mem_reg[rd_ptr_reg];
   assign occ     = occ_reg;

   // One register per entry; storage is cleared on reset so the head reads '0.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_reg[gi] <= '0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
               mem_reg[gi] <= din;
            end
         end
      end
   endgenerate

   // Pointers wrap explicitly so non-power-of-two depths also work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (pop_eff) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
         end
         case ({push, pop_eff})
            2'b10:   occ_reg <= occ_reg + 1'b1;
            2'b01:   occ_reg <= occ_reg - 1'b1;
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   // The upstream credit rule guarantees a free slot for every capture.
   overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
                                !(push && (occ_reg == OCC_W'(DEPTH))));

endmodule

// File: rtl/cr_tlvp_ob_axis.sv
// -----------------------------------------------------------------------------
// cr_tlvp_ob_axis
// Egress stage of the TLV parser: pops beats from the parser output FIFO
// (1-cycle read latency), buffers them in cr_tlvp_ob_buf and presents them as
// an AXI4-stream master. Tracks frame boundaries on tlast.
// Optional per-frame statistics are built when CR_TLVP_OB_STATS_EN is defined;
// otherwise stat_beats / stat_frames are tied to 0.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   tlvp_ob_empty       : parser FIFO empty
//   tlvp_ob_aempty      : parser FIFO almost empty (not used for issue)
//   tlvp_ob             : parser read data, valid the cycle after tlvp_ob_rd
//   tlvp_ob_rd          : pop request to parser FIFO
//   out_tvalid/tready   : AXI4-stream handshake
//   out_axi             : beat presented (head of local buffer)
//   frame_active        : inside a multi-beat frame
//   stat_beats          : beats in last completed frame
//   stat_frames         : completed frames since reset (wraps)
// -----------------------------------------------------------------------------
module cr_tlvp_ob_axis
   import cr_tlvp_ob_axis_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tlvp_ob_empty,
   input  logic             tlvp_ob_aempty,
   input  axi4s_dp_bus_t    tlvp_ob,
   output logic             tlvp_ob_rd,
   output logic             out_tvalid,
   input  logic             out_tready,
   output axi4s_dp_bus_t    out_axi,
   output logic             frame_active,
   output logic [CNT_W-1:0] stat_beats,
   output logic [CNT_W-1:0] stat_frames
);

   localparam int OCC_W = occ_width(DEPTH);
   localparam int SUM_W = OCC_W + 1;

   logic                inflight_reg;
   logic [OCC_W-1:0]    occ;
   logic                pop;
   logic                aempty_unused;
   tlvp_ob_axis_state_e state_reg;
   tlvp_ob_axis_state_e state_next;

   assign aempty_unused = tlvp_ob_aempty;

   // Credit check uses registered occupancy and in-flight only, so there is no
   // combinational path from out_tready to tlvp_ob_rd.
   assign tlvp_ob_rd = rst_n && !tlvp_ob_empty &&
                       ((SUM_W'(occ) + SUM_W'(inflight_reg)) < SUM_W'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight_reg <= 1'b0;
      else        inflight_reg <= tlvp_ob_rd;
   end

   cr_tlvp_ob_buf #(
      .DEPTH (DEPTH),
      .OCC_W (OCC_W)
   ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight_reg),
      .din   (tlvp_ob),
      .pop   (pop),
      .dout  (out_axi),
      .occ   (occ)
   );

   assign out_tvalid = (occ != '0);
   assign pop        = out_tvalid && out_tready;

   // Frame tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (pop) begin
         state_next = out_axi.tlast ? IDLE : ACTIVE;
      end
   end

   assign frame_active = (state_reg == ACTIVE);

`ifdef CR_TLVP_OB_STATS_EN
   logic [CNT_W-1:0] beat_cnt_reg;
   logic [CNT_W-1:0] stat_beats_reg;
   logic [CNT_W-1:0] stat_frames_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_reg    <= '0;
         stat_beats_reg  <= '0;
         stat_frames_reg <= '0;
      end else if (pop) begin
         if (out_axi.tlast) begin
            beat_cnt_reg    <= '0;
            stat_beats_reg  <= beat_cnt_reg + 1'b1;
            stat_frames_reg <= stat_frames_reg + 1'b1;
         end else begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
         end
      end
   end

   assign stat_beats  = stat_beats_reg;
   assign stat_frames = stat_frames_reg;
`else
   assign stat_beats  = '0;
   assign stat_frames = '0;
`endif

endmodule

// File: tb/tb_cr_tlvp_ob_axis.sv
// -----------------------------------------------------------------------------
// tb_cr_tlvp_ob_axis
// Directed bench for cr_tlvp_ob_axis: reset, latency, throughput, backpressure,
// frame tracking / stats and a randomised soak against a beat scoreboard.
// -----------------------------------------------------------------------------
module tb_cr_tlvp_ob_axis;
   import cr_tlvp_ob_axis_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tlvp_ob_empty;
   logic             tlvp_ob_aempty;
   axi4s_dp_bus_t    tlvp_ob;
   logic             tlvp_ob_rd;
   logic             out_tvalid;
   logic             out_tready;
   axi4s_dp_bus_t    out_axi;
   logic             frame_active;
   logic [CNT_W-1:0] stat_beats;
   logic [CNT_W-1:0] stat_frames;

   always #5 clk = ~clk;

   cr_tlvp_ob_axis #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tlvp_ob_empty  (tlvp_ob_empty),
      .tlvp_ob_aempty (tlvp_ob_aempty),
      .tlvp_ob        (tlvp_ob),
      .tlvp_ob_rd     (tlvp_ob_rd),
      .out_tvalid     (out_tvalid),
      .out_tready     (out_tready),
      .out_axi        (out_axi),
      .frame_active   (frame_active),
      .stat_beats     (stat_beats),
      .stat_frames    (stat_frames)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_issue = 0;
   int            n_acc = 0;
   axi4s_dp_bus_t src_q[$];
   axi4s_dp_bus_t exp_q[$];
   logic          pend_rd = 1'b0;
   logic          empty_gate = 1'b0;
   logic          tready_drv = 1'b0;
   logic          exp_active = 1'b0;
   logic          stall_prev = 1'b0;
   axi4s_dp_bus_t stall_data;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic axi4s_dp_bus_t mk(input logic [63:0] d, input logic l);
      axi4s_dp_bus_t b;
      b.tdata = d;
      b.tkeep = 8'hFF;
      b.tuser = d[7:0];
      b.tlast = l;
      return b;
   endfunction

   task automatic add_beat(input logic [63:0] d, input logic l);
      axi4s_dp_bus_t b;
      b = mk(d, l);
      src_q.push_back(b);
      exp_q.push_back(b);
   endtask

   // One clock cycle: model the parser FIFO (1-cycle read latency), drive
   // inputs on the falling edge, then check outputs before the next rising edge.
   task automatic cycle();
      axi4s_dp_bus_t e;
      @(negedge clk);
      if (pend_rd) begin
         if (src_q.size() > 0) tlvp_ob = src_q.pop_front();
         else chk("src_underflow", 128'(1), 128'(0));
      end
      tlvp_ob_empty  = empty_gate || (src_q.size() == 0);
      tlvp_ob_aempty = (src_q.size() < 2);
      out_tready     = tready_drv;
      #1;
      chk("frame_active", 128'(frame_active), 128'(exp_active));
      if (stall_prev) begin
         chk("stable_valid", 128'(out_tvalid), 128'(1));
         chk("stable_data", 128'(out_axi), 128'(stall_data));
      end
      pend_rd = tlvp_ob_rd;
      if (tlvp_ob_rd) n_issue++;
      stall_prev = out_tvalid && !out_tready;
      stall_data = out_axi;
      if (out_tvalid && out_tready) begin
         n_acc++;
         if (exp_q.size() == 0) begin
            chk("sb_extra", 128'(1), 128'(0));
         end else begin
            e = exp_q.pop_front();
            chk("sb_beat", 128'(out_axi), 128'(e));
            $display("beat %0d tdata=%h tlast=%b", n_acc, out_axi.tdata, out_axi.tlast);
            exp_active = !e.tlast;
         end
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, 128'(exp_q.size()), 128'(0));
      repeat (2) cycle();
   endtask

   task automatic chk_stats(input string tag, input int beats, input int frames);
`ifdef CR_TLVP_OB_STATS_EN
      chk({tag, "_beats"}, 128'(stat_beats), 128'(beats));
      chk({tag, "_frames"}, 128'(stat_frames), 128'(frames));
`else
      chk({tag, "_beats"}, 128'(stat_beats), 128'(0 * beats));
      chk({tag, "_frames"}, 128'(stat_frames), 128'(0 * frames));
`endif
   endtask

   initial begin
      int cyc;
      int n;

      rst_n          = 1'b0;
      tlvp_ob        = '0;
      tlvp_ob_empty  = 1'b1;
      tlvp_ob_aempty = 1'b1;
      out_tready     = 1'b0;

      // Reset state: rd held low even with a non-empty source
      repeat (2) @(negedge clk);
      tlvp_ob_empty = 1'b0;
      #1;
      chk("rst_rd", 128'(tlvp_ob_rd), 128'(0));
      chk("rst_tvalid", 128'(out_tvalid), 128'(0));
      chk("rst_axi", 128'(out_axi), 128'(0));
      chk("rst_frame", 128'(frame_active), 128'(0));
      chk_stats("rst", 0, 0);
      tlvp_ob_empty = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: reset mid-frame with three beats buffered
      n_issue = 0;
      add_beat(64'h11, 1'b0);
      add_beat(64'h12, 1'b0);
      add_beat(64'h13, 1'b0);
      add_beat(64'h14, 1'b1);
      tready_drv = 1'b0;
      repeat (8) cycle();
      chk("t1_issue", 128'(n_issue), 128'(4));
      tready_drv = 1'b1;
      cycle();
      tready_drv = 1'b0;
      cycle();
      chk("t1_frame_pre", 128'(frame_active), 128'(1));
      @(negedge clk);
      rst_n         = 1'b0;
      tlvp_ob_empty = 1'b0;
      #1;
      chk("t1_tvalid", 128'(out_tvalid), 128'(0));
      chk("t1_rd", 128'(tlvp_ob_rd), 128'(0));
      chk("t1_frame", 128'(frame_active), 128'(0));
      chk_stats("t1", 0, 0);
      src_q.delete();
      exp_q.delete();
      pend_rd       = 1'b0;
      exp_active    = 1'b0;
      stall_prev    = 1'b0;
      tlvp_ob_empty = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cycle();

      // Test 2: latency rd@0, tvalid@2
      tready_drv = 1'b1;
      add_beat(64'hA5, 1'b1);
      cycle();
      chk("t2_rd0", 128'(tlvp_ob_rd), 128'(1));
      chk("t2_tvalid0", 128'(out_tvalid), 128'(0));
      cycle();
      chk("t2_tvalid1", 128'(out_tvalid), 128'(0));
      cycle();
      chk("t2_tvalid2", 128'(out_tvalid), 128'(1));
      chk("t2_data", 128'(out_axi.tdata), 128'(64'hA5));
      drain("t2_drain", 10);

      // Test 3: 64 beats, one per cycle after 2-cycle fill
      n_acc = 0;
      for (int i = 0; i < 64; i++) add_beat(64'h3000 + 64'(i), (i % 8) == 7);
      cyc = 0;
      while (n_acc < 64 && cyc < 200) begin
         cycle();
         cyc++;
      end
      chk("t3_cycles", 128'(cyc), 128'(66));
      drain("t3_drain", 10);

      // Test 4: backpressure for 20 cycles
      n_issue    = 0;
      tready_drv = 1'b0;
      for (int i = 0; i < 10; i++) add_beat(64'h4000 + 64'(i), i == 9);
      repeat (20) cycle();
      chk("t4_issue", 128'(n_issue), 128'(4));
      chk("t4_pending", 128'(exp_q.size()), 128'(10));
      tready_drv = 1'b1;
      drain("t4_drain", 50);

      // Test 5: 3-beat frame then 1-beat frame
      add_beat(64'h51, 1'b0);
      add_beat(64'h52, 1'b0);
      add_beat(64'h53, 1'b1);
      drain("t5a_drain", 20);
      chk("t5a_frame", 128'(frame_active), 128'(0));
      chk_stats("t5a", 3, 11);
      add_beat(64'h54, 1'b1);
      drain("t5b_drain", 20);
      chk_stats("t5b", 1, 12);

      // Test 6: random tready / empty, 1000 beats
      for (int i = 0; i < 1000; i++) begin
         add_beat({$urandom, $urandom}, ($urandom_range(0, 3) == 0) || (i == 999));
      end
      n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         tready_drv = 1'($urandom_range(0, 1));
         empty_gate = ($urandom_range(0, 9) < 3);
         cycle();
         n++;
      end
      chk("t6_drain", 128'(exp_q.size()), 128'(0));
      empty_gate = 1'b0;
      tready_drv = 1'b1;
      repeat (4) cycle();
      chk("t6_idle_tvalid", 128'(out_tvalid), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
